// File: rtl/ste_shift_ctrl.sv
// Word-level sequencer for ste_shift_reg: parallel load, paced shift-enable pulses, capture to an rx port.
// Optional rx backpressure (WAIT_RX state, no overwrite) is enabled by defining STE_SHIFT_CTRL_BACKPRESSURE_EN.
module ste_shift_ctrl #(
  parameter int SHIFT_W = 24,
  parameter int DIV_W   = 8
) (
  input  logic               clk,
  input  logic               reset_i,
  input  logic [DIV_W-1:0]   cfg_div_i,
  input  logic               abort_i,
  input  logic [SHIFT_W-1:0] tx_data_i,
  input  logic               tx_valid_i,
  output logic               tx_ready_o,
  output logic [SHIFT_W-1:0] rx_data_o,
  output logic               rx_valid_o,
  input  logic               rx_ready_i,
  output logic               busy_o,
  output logic               overrun_o,
  output logic               shift_clr_o,
  output logic               shift_ld_o,
  output logic               shift_en_o,
  output logic [SHIFT_W-1:0] din_parallel_o,
  input  logic [SHIFT_W-1:0] dout_parallel_i
);

  localparam int CNT_W = $clog2(SHIFT_W + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_CAPTURE
`ifdef STE_SHIFT_CTRL_BACKPRESSURE_EN
    , ST_WAIT_RX
`endif
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [DIV_W-1:0]   div_lat_q, div_lat_d;
  logic [SHIFT_W-1:0] din_q, din_d;
  logic [SHIFT_W-1:0] rx_data_q, rx_data_d;
  logic               rx_valid_q, rx_valid_d;
  logic               overrun_q, overrun_d;
  logic               accept;
  logic               capture;

  // State register and datapath flops
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      div_cnt_q  <= '0;
      div_lat_q  <= '0;
      din_q      <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      div_cnt_q  <= div_cnt_d;
      div_lat_q  <= div_lat_d;
      din_q      <= din_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      overrun_q  <= overrun_d;
    end
  end

  // Next-state logic; abort overrides every state
  always_comb begin
    state_d = state_q;
    if (abort_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:    if (tx_valid_i && tx_ready_o) state_d = ST_LOAD;
        ST_LOAD:    state_d = ST_SHIFT;
        ST_SHIFT:   if (div_cnt_q == '0 && bit_cnt_q == CNT_W'(1)) state_d = ST_CAPTURE;
`ifdef STE_SHIFT_CTRL_BACKPRESSURE_EN
        ST_CAPTURE: state_d = ST_WAIT_RX;
        ST_WAIT_RX: if (rx_valid_q && rx_ready_i) state_d = ST_IDLE;
`else
        ST_CAPTURE: state_d = ST_IDLE;
`endif
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs: decoded from state, counters and abort only
  always_comb begin
`ifdef STE_SHIFT_CTRL_BACKPRESSURE_EN
    tx_ready_o = (state_q == ST_IDLE) && !abort_i && !rx_valid_q;
`else
    tx_ready_o = (state_q == ST_IDLE) && !abort_i;
`endif
    shift_ld_o     = (state_q == ST_LOAD) && !abort_i;
    shift_en_o     = (state_q == ST_SHIFT) && (div_cnt_q == '0) && !abort_i;
    shift_clr_o    = abort_i;
    busy_o         = (state_q != ST_IDLE);
    din_parallel_o = din_q;
    rx_data_o      = rx_data_q;
    rx_valid_o     = rx_valid_q;
    overrun_o      = overrun_q;
  end

  // Counters, latches and rx port
  always_comb begin
    accept    = (state_q == ST_IDLE) && tx_valid_i && tx_ready_o;
    capture   = (state_q == ST_CAPTURE) && !abort_i;
    div_lat_d = accept ? cfg_div_i : div_lat_q;
    din_d     = accept ? tx_data_i : din_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;
    if (abort_i) begin
      bit_cnt_d = '0;
      div_cnt_d = '0;
    end else if (state_q == ST_LOAD) begin
      bit_cnt_d = CNT_W'(SHIFT_W);
      div_cnt_d = div_lat_q;
    end else if (state_q == ST_SHIFT) begin
      if (div_cnt_q == '0) begin
        div_cnt_d = div_lat_q;
        bit_cnt_d = bit_cnt_q - CNT_W'(1);
      end else begin
        div_cnt_d = div_cnt_q - DIV_W'(1);
      end
    end
    rx_valid_d = rx_valid_q;
    if (capture) rx_valid_d = 1'b1;
    else if (rx_valid_q && rx_ready_i) rx_valid_d = 1'b0;
    rx_data_d = capture ? dout_parallel_i : rx_data_q;
`ifdef STE_SHIFT_CTRL_BACKPRESSURE_EN
    overrun_d = 1'b0;
`else
    overrun_d = overrun_q | (capture && rx_valid_q && !rx_ready_i);
`endif
  end

endmodule

// File: tb/tb_ste_shift_ctrl.sv
// Scoreboard bench for ste_shift_ctrl with a looped-back shift register model and randomized traffic.
module tb_ste_shift_ctrl;
  localparam int SW = 24;

  logic          clk;
  logic          reset_i;
  logic [7:0]    cfg_div_i;
  logic          abort_i;
  logic [SW-1:0] tx_data_i;
  logic          tx_valid_i;
  logic          tx_ready_o;
  logic [SW-1:0] rx_data_o;
  logic          rx_valid_o;
  logic          rx_ready_i;
  logic          busy_o;
  logic          overrun_o;
  logic          shift_clr_o;
  logic          shift_ld_o;
  logic          shift_en_o;
  logic [SW-1:0] din_parallel_o;
  logic [SW-1:0] dout_parallel_i;

  ste_shift_ctrl #(.SHIFT_W(SW), .DIV_W(8)) dut (
    .clk(clk), .reset_i(reset_i), .cfg_div_i(cfg_div_i), .abort_i(abort_i),
    .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
    .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
    .busy_o(busy_o), .overrun_o(overrun_o), .shift_clr_o(shift_clr_o),
    .shift_ld_o(shift_ld_o), .shift_en_o(shift_en_o),
    .din_parallel_o(din_parallel_o), .dout_parallel_i(dout_parallel_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Attached shift register, serial input looped from its msb
  logic [SW-1:0] sr;
  always @(posedge clk or posedge reset_i) begin
    if (reset_i)          sr <= '0;
    else if (shift_clr_o) sr <= '0;
    else if (shift_ld_o)  sr <= din_parallel_o;
    else if (shift_en_o)  sr <= {sr[SW-2:0], sr[SW-1]};
  end
  assign dout_parallel_i = sr;

  // rx_ready driver: 0 = hold low, 1 = hold high, 2 = random
  int rx_mode = 1;
  always @(posedge clk) begin
    #2;
    case (rx_mode)
      0:       rx_ready_i = 1'b0;
      1:       rx_ready_i = 1'b1;
      default: rx_ready_i = 1'($urandom_range(0, 1));
    endcase
  end

  int errors = 0;
  int n_checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [SW-1:0] data;
    int            acc;
    int            div;
    int            due;
  } entry_t;

  entry_t q[$];
  int     pulse_total = 0;

  // Monitor: every word accepted must come back unchanged SHIFT_W*(div+1)+2 cycles later
  int            k = 0;
  logic          ov_exp = 1'b0;
  logic          pv = 1'b0;
  logic          pr = 1'b0;
  logic [SW-1:0] pdata = '0;
  always @(negedge clk) begin
    if (reset_i) begin
      q.delete();
      k = 0; ov_exp = 1'b0; pv = 1'b0; pr = 1'b0; pdata = '0;
    end else begin
      if (q.size() == 0) check("pulse_idle", shift_en_o, 0);
      else if (shift_en_o) begin
        pulse_total++;
        check("pulse_time", cyc, q[0].acc + 1 + q[0].div + k * (q[0].div + 1));
        k++;
      end
      if (busy_o) check("tx_ready_busy", tx_ready_o, 0);
`ifdef STE_SHIFT_CTRL_BACKPRESSURE_EN
      if (rx_valid_o) check("tx_ready_rxfull", tx_ready_o, 0);
`endif
      if (q.size() != 0 && cyc == q[0].due) begin
        ov_exp = ov_exp | (pv && !pr);
        check("rx_valid_due", rx_valid_o, 1);
        check("rx_data", rx_data_o, q[0].data);
        check("pulse_count", k, SW);
        check("overrun", overrun_o, ov_exp);
        void'(q.pop_front());
        k = 0;
      end else if (!pv) begin
        check("rx_valid_low", rx_valid_o, 0);
      end else if (pr) begin
        check("rx_valid_clear", rx_valid_o, 0);
      end else begin
        check("rx_valid_hold", rx_valid_o, 1);
        check("rx_data_hold", rx_data_o, pdata);
      end
      if (abort_i && busy_o && q.size() != 0) begin
        void'(q.pop_front());
        k = 0;
      end
      pv = rx_valid_o; pr = rx_ready_i; pdata = rx_data_o;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [SW-1:0] w, input int div, output int acc);
    int n = 0;
    acc = -1;
    tx_data_i = w; cfg_div_i = 8'(div); tx_valid_i = 1'b1;
    while (!tx_ready_o && n < 1000) begin tick(); n++; end
    if (!tx_ready_o) begin
      check("tx_accept_timeout", tx_ready_o, 1);
      tx_valid_i = 1'b0;
      return;
    end
    tick();
    acc = cyc;
    q.push_back('{w, acc, div, acc + SW * (div + 1) + 2});
    tx_valid_i = 1'b0;
    tx_data_i = 24'($urandom);
    check("load_pulse", shift_ld_o, 1);
    check("load_word", din_parallel_o, w);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!(q.size() == 0 && !busy_o) && n < 2000) begin tick(); n++; end
    check("done_timeout", (q.size() == 0 && !busy_o), 1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_tx_ready"}, tx_ready_o, 1);
    check({tag, "_rx_valid"}, rx_valid_o, 0);
    check({tag, "_rx_data"}, rx_data_o, 0);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_overrun"}, overrun_o, 0);
    check({tag, "_shift_clr"}, shift_clr_o, 0);
    check({tag, "_shift_ld"}, shift_ld_o, 0);
    check({tag, "_shift_en"}, shift_en_o, 0);
    check({tag, "_din"}, din_parallel_o, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int p0;
    int n;
    reset_i = 1'b1; abort_i = 1'b0; tx_valid_i = 1'b0; tx_data_i = '0; cfg_div_i = '0;
    repeat (3) tick();
    reset_i = 1'b0;
    check_reset_values("reset");

    rx_mode = 1;
    send(24'h234567, 0, acc);
    wait_done();
    send(24'haaaaaa, 3, acc);
    wait_done();

    // Abort on the 10th pulse (div=1: pulses at acc+2+2k)
    send(24'hffffff, 1, acc);
    p0 = pulse_total;
    n = 0;
    while (cyc != acc + 20 && n < 100) begin tick(); n++; end
    abort_i = 1'b1;
    @(negedge clk); #1;
    check("abort_clr", shift_clr_o, 1);
    check("abort_en", shift_en_o, 0);
    check("abort_tx_ready", tx_ready_o, 0);
    tick();
    abort_i = 1'b0;
    check("abort_idle", busy_o, 0);
    check("abort_shift_clr_drop", shift_clr_o, 0);
    check("abort_pulses", pulse_total - p0, 9);
    repeat (30) tick();
    check("abort_no_rx", rx_valid_o, 0);

`ifdef STE_SHIFT_CTRL_BACKPRESSURE_EN
    rx_mode = 0;
    send(24'h000001, 0, acc);
    n = 0;
    while (!rx_valid_o && n < 100) begin tick(); n++; end
    check("bp_rx_valid", rx_valid_o, 1);
    repeat (8) begin
      tick();
      check("bp_tx_ready", tx_ready_o, 0);
      check("bp_rx_data", rx_data_o, 24'h000001);
    end
    rx_mode = 1;
    tick();
    tick();
    check("bp_release_tx_ready", tx_ready_o, 1);
`else
    rx_mode = 0;
    send(24'h111111, 0, acc);
    send(24'hdfeabc, 0, acc);
    wait_done();
    check("ovr_rx_data", rx_data_o, 24'hdfeabc);
    check("ovr_flag", overrun_o, 1);
    repeat (5) tick();
    rx_mode = 1;
    repeat (3) tick();
    check("ovr_sticky", overrun_o, 1);
    check("ovr_consumed", rx_valid_o, 0);
`endif

    // Asynchronous reset mid-SHIFT, off the clock edge
    rx_mode = 1;
    send(24'h123456, 2, acc);
    repeat (10) tick();
    #2;
    reset_i = 1'b1;
    #1;
    check_reset_values("async_reset");
    tick();
    tick();
    reset_i = 1'b0;
    send(24'h555555, 0, acc);
    wait_done();

    rx_mode = 2;
    for (int i = 0; i < 20; i++) begin
      send(24'($urandom), int'($urandom_range(0, 3)), acc);
      repeat ($urandom_range(0, 3)) tick();
    end
    rx_mode = 1;
    wait_done();
    repeat (4) tick();
    check("queue_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, n_checks);
    $finish;
  end
endmodule
